// File: rtl/servant_uart.sv
// Wishbone UART: TX FIFO feeding an 8N1 serialiser with a programmable baud divisor.
// Optional single-byte receiver is built when SERVANT_UART_RX_EN is defined.
module servant_uart #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   input  logic        i_rx,
   output logic        o_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   logic          r_ack, r_tx, r_txovr;
   logic [31:0]   r_rdt;
   logic [15:0]   r_div, r_cnt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   tx_state_t     r_state, w_next;

   logic [1:0]  w_adr;
   logic        w_req, w_wr, w_rd, w_wr_data, w_wr_stat, w_wr_div, w_rd_data;
   logic        w_full, w_empty, w_busy, w_push, w_pop, w_ovr, w_tick;
   logic [15:0] w_div_wr;
   logic [31:0] w_rdata;
   logic        w_rxv, w_rxovr, w_ferr;
   logic [7:0]  w_rx_byte;
   logic        w_unused;

   assign w_unused  = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};
   assign w_adr     = i_wb_adr[3:2];
   assign w_req     = i_wb_cyc & ~r_ack;
   assign w_wr      = w_req & i_wb_we;
   assign w_rd      = w_req & ~i_wb_we;
   assign w_wr_data = w_wr & (w_adr == 2'd0) & i_wb_sel[0];
   assign w_wr_stat = w_wr & (w_adr == 2'd1) & i_wb_sel[0];
   assign w_wr_div  = w_wr & (w_adr == 2'd2) & (|i_wb_sel[1:0]);
   assign w_rd_data = w_rd & (w_adr == 2'd0);
   assign w_div_wr  = {i_wb_sel[1] ? i_wb_dat[15:8] : r_div[15:8],
                       i_wb_sel[0] ? i_wb_dat[7:0]  : r_div[7:0]};

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_busy  = (r_state != S_IDLE) | ~w_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_push  = w_wr_data & (~w_full | w_pop);
   assign w_ovr   = w_wr_data & w_full & ~w_pop;
   assign w_tick  = (r_cnt == 16'd0);

   always_comb begin
      w_rdata = '0;
      case (w_adr)
         2'd0:    w_rdata = {24'b0, w_rx_byte};
         2'd1:    w_rdata = {25'b0, w_ferr, w_rxovr, w_rxv, r_txovr, w_busy, w_empty, w_full};
         2'd2:    w_rdata = {16'b0, r_div};
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_ack   <= 1'b0;
         r_rdt   <= '0;
         r_div   <= DIV_RESET;
         r_txovr <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_rdt <= w_rd ? w_rdata : 32'd0;
         if (w_wr_div)
            r_div <= (w_div_wr < 16'd2) ? 16'd2 : w_div_wr;
         if (w_ovr)
            r_txovr <= 1'b1;
         else if (w_wr_stat && i_wb_dat[3])
            r_txovr <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_wb_dat[7:0];
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_next = S_START;
         S_START: if (w_tick) w_next = S_DATA;
         S_DATA:  if (w_tick && r_bitcnt == 3'd7) w_next = S_STOP;
         S_STOP:  if (w_tick) w_next = w_empty ? S_IDLE : S_START;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop = 1'b0;
      if (!w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick)))
         w_pop = 1'b1;
   end

   // The counter reloads from r_div only at bit boundaries, so a new divisor waits for the next bit.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_tx     <= 1'b1;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else if (w_pop) begin
         r_tx     <= 1'b0;
         r_shift  <= r_mem[r_rptr];
         r_cnt    <= r_div - 16'd1;
         r_bitcnt <= '0;
      end else if (r_state != S_IDLE) begin
         if (!w_tick) begin
            r_cnt <= r_cnt - 16'd1;
         end else begin
            r_cnt <= r_div - 16'd1;
            case (r_state)
               S_START: begin
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end
               S_DATA: begin
                  if (r_bitcnt == 3'd7) begin
                     r_tx <= 1'b1;
                  end else begin
                     r_tx     <= r_shift[0];
                     r_shift  <= {1'b0, r_shift[7:1]};
                     r_bitcnt <= r_bitcnt + 3'd1;
                  end
               end
               default: r_tx <= 1'b1;
            endcase
         end
      end
   end

`ifdef SERVANT_UART_RX_EN
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   rx_state_t   r_rx_state, w_rx_next;
   logic        r_rx_s1, r_rx_s2, r_rx_d, r_rxv, r_rxovr, r_ferr;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_sh, r_rx_byte;
   logic        w_rx_tick, w_rx_fall, w_rx_done;

   assign w_rx_tick = (r_rx_cnt == 16'd0);
   assign w_rx_fall = r_rx_d & ~r_rx_s2;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_rx_state <= R_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         R_IDLE:  if (w_rx_fall) w_rx_next = R_START;
         R_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = R_STOP;
         R_STOP:  if (w_rx_tick) w_rx_next = R_IDLE;
         default: w_rx_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_rx_done = (r_rx_state == R_STOP) && w_rx_tick;
   end

   // Idle preloads half a bit so the start bit is re-checked mid-bit before committing.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_rx_s1 <= 1'b1;  r_rx_s2 <= 1'b1;  r_rx_d <= 1'b1;
         r_rx_cnt <= '0;   r_rx_bit <= '0;   r_rx_sh <= '0;   r_rx_byte <= '0;
         r_rxv <= 1'b0;    r_rxovr <= 1'b0;  r_ferr <= 1'b0;
      end else begin
         r_rx_s1 <= i_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
         if (r_rx_state == R_IDLE)  r_rx_cnt <= (r_div >> 1) - 16'd1;
         else if (w_rx_tick)        r_rx_cnt <= r_div - 16'd1;
         else                       r_rx_cnt <= r_rx_cnt - 16'd1;
         if (r_rx_state == R_START) r_rx_bit <= '0;
         if (r_rx_state == R_DATA && w_rx_tick) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
         end
         if (w_rx_done && !r_rxv) begin
            r_rx_byte <= r_rx_sh;
            r_rxv     <= 1'b1;
         end else if (w_rd_data) begin
            r_rxv <= 1'b0;
         end
         if (w_rx_done && r_rxv)                r_rxovr <= 1'b1;
         else if (w_wr_stat && i_wb_dat[5])     r_rxovr <= 1'b0;
         if (w_rx_done && !r_rx_s2)             r_ferr  <= 1'b1;
         else if (w_wr_stat && i_wb_dat[6])     r_ferr  <= 1'b0;
      end
   end

   assign w_rxv     = r_rxv;
   assign w_rxovr   = r_rxovr;
   assign w_ferr    = r_ferr;
   assign w_rx_byte = r_rx_byte;
`else
   logic w_unused_rx;
   assign w_unused_rx = i_rx;
   assign w_rxv       = 1'b0;
   assign w_rxovr     = 1'b0;
   assign w_ferr      = 1'b0;
   assign w_rx_byte   = 8'd0;
`endif

   assign o_wb_ack = r_ack;
   assign o_wb_rdt = r_rdt;
   assign o_tx     = r_tx;
endmodule

// File: doc/servant_uart.md
# servant_uart

Wishbone slave UART peripheral that sits directly downstream of `servant_mux` as an extra slave port, alongside the gpio and timer slaves. It accepts bytes from the CPU into a TX FIFO and serialises them as 8N1 frames on `o_tx`, with a programmable baud divisor. It provides the console output path for firmware. An optional single-byte receiver can be compiled in.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two and at least 2.
- `DIV_RESET`, 16'd434: divisor reset value, in clocks per bit (50 MHz / 115200).
- `i_clk` in 1: system clock (`wb_clk`).
- `i_nrst` in 1: reset; asynchronous assert, active-low.
- `i_wb_adr` in 32: byte address; only `[3:2]` is decoded.
- `i_wb_dat` in 32: write data.
- `i_wb_sel` in 4: byte enables.
- `i_wb_we` in 1: write strobe.
- `i_wb_cyc` in 1: cycle request.
- `o_wb_rdt` out 32: read data.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `i_rx` in 1: serial input; ignored unless RX is compiled in.
- `o_tx` out 1: serial output; idle high.

## Operation
Register map, decoded on `adr[3:2]`:
- **0 DATA**
  - Write with `sel[0]` pushes `dat[7:0]` into the TX FIFO.
  - A push while the FIFO is full is dropped and sets sticky `TXOVR`.
  - A read returns `{24'b0, rx_byte}` and clears `RXV`; the read returns 0 when RX is absent.
- **1 STATUS** (read)
  - `[0]` TXFULL, `[1]` TXEMPTY, `[2]` TXBUSY (FSM not IDLE, or FIFO non-empty).
  - `[3]` TXOVR, `[4]` RXV, `[5]` RXOVR, `[6]` FERR; all other bits 0.
  - Write: each 1 in `dat[3]`, `[5]`, `[6]` clears that sticky bit (requires `sel[0]`).
- **2 DIVISOR**: 16-bit, written with `sel[1:0]` per byte.
  - A value below 2 is stored as 2.
  - A read returns `{16'b0, div}`.
- **3**: reads 0; writes are ignored.

TX FSM: IDLE → START → DATA → STOP.
- **IDLE**: if the FIFO is non-empty, pop into the shift register, drive `o_tx` low and go to START.
- **START**: hold for one bit period, then go to DATA.
- **DATA**: shift out 8 bits LSB first, one bit period each, then go to STOP.
- **STOP**: drive `o_tx` high for one bit period.
  - At the end of the period, pop immediately if the FIFO is non-empty (→ START, no idle gap).
  - Otherwise return to IDLE.
- Bit period: `div` clocks, from a down-counter reloaded with `div-1` at each bit boundary.
- A divisor change takes effect at the next bit boundary; the current bit is not disturbed.

FIFO rules:
- Occupancy counter width is `$clog2(FIFO_DEPTH)+1`; pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted.
- Simultaneous push and pop when empty: cannot occur, because a pop requires a non-empty FIFO at the edge.

## Timing
- Reset values:
  - `o_tx`=1, `o_wb_ack`=0, `o_wb_rdt`=0, FSM=IDLE.
  - FIFO empty, all sticky bits 0, `div`=`DIV_RESET`, RXV=0.
- Bus handshake:
  - `o_wb_ack` rises on the edge after `cyc` is sampled high with `ack` low, and lasts one cycle.
  - `o_wb_rdt` is registered and valid only while ack is high; it is 0 otherwise.
  - Write side effects commit on the ack edge.
- TX latency: DATA write acked at edge N → `o_tx` falls at edge N+1 if the FSM is IDLE. A full frame is exactly `10*div` clocks.
- Asserting `i_nrst` mid-frame forces `o_tx` high asynchronously and discards FIFO contents. On release, the FSM starts cleanly from IDLE.

## Configuration
- `SERVANT_UART_RX_EN` defined: the receiver is built.
  - `i_rx` passes through a two-flop synchroniser.
  - A falling edge in RX-IDLE starts a `div/2` wait; if the line is no longer low, the RX FSM returns to idle (glitch rejected).
  - Otherwise it samples 8 data bits at `div` intervals, then the stop bit. A stop bit of 0 sets FERR.
  - The byte is written to a 1-entry holding register and RXV is set.
  - If RXV is already set, the new byte is discarded and RXOVR is set.
- Not defined: no RX logic; `i_rx` is unused; STATUS `[6:4]` and DATA reads return 0.

## Test plan
- Reset, then read STATUS → `0x00000002`; `o_tx`=1; DIVISOR reads `0x000001B2`.
- Write DIVISOR=4, then DATA=0x55 → `o_tx` low at the edge after ack; bit pattern 0,1,0,1,0,1,0,1,0,1 with each bit 4 clocks; 40-clock frame; TXBUSY clears afterwards.
- Write 9 bytes back-to-back with DIVISOR=2 → bytes 1–8 transmitted with no gap between frames; byte 9 transmitted only if a pop freed a slot first, else TXOVR=1; writing STATUS=0x8 clears TXOVR.
- Write DIVISOR=1 → reads back 2; write DIVISOR=8 mid-frame → the current bit still uses the old period, the next bit uses 8 clocks.
- Pulse `i_nrst` low during the DATA phase → `o_tx`=1 immediately; STATUS=`0x2` after release.
- With `SERVANT_UART_RX_EN`:
  - Loop `o_tx` to `i_rx` and send 0xA3 → RXV=1 and DATA reads 0xA3, after which RXV=0.
  - Send a second byte without reading → RXOVR=1 and the first byte is kept.
  - Force a stop bit of 0 → FERR=1.
